// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple-carry step per clock, LSB nibble first,
// with valid/ready handshakes on the operand and result sides.
module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);
  localparam int N  = WIDTH / 4;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ws_q, ws_d, sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d;

  // Nibble slice: low nibbles of the working operands plus the running carry.
  logic [4:0] nib;
  assign nib = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, c_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    ws_d    = ws_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          c_d     = carry_i;
          ws_d    = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Sum nibbles enter at the top so nibble 0 ends up at the bottom after N steps.
        ws_d  = WIDTH'({nib[3:0], ws_q} >> 4);
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        c_d   = nib[4];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = ws_d;
          cout_d  = nib[4];
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ws_q    <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ws_q    <= ws_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign sum_o   = sum_q;
  assign carry_o = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed cases plus random back-to-back ops on WIDTH=32
// and WIDTH=4 instances, checked against a plain a+b+cin reference.
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst;
  logic        v32, r32_o, c32, vo32, ri32, co32;
  logic [31:0] a32, b32, s32;
  logic        v4, r4_o, c4, vo4, ri4, co4;
  logic [3:0]  a4, b4, s4;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(32)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .valid_i(v32), .ready_o(r32_o), .a_i(a32), .b_i(b32),
    .carry_i(c32), .valid_o(vo32), .ready_i(ri32), .sum_o(s32), .carry_o(co32));

  nibble_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(v4), .ready_o(r4_o), .a_i(a4), .b_i(b4),
    .carry_i(c4), .valid_o(vo4), .ready_i(ri4), .sum_o(s4), .carry_o(co4));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int w);
    return (w == 32) ? r32_o : r4_o;
  endfunction
  function automatic logic vld(input int w);
    return (w == 32) ? vo32 : vo4;
  endfunction
  function automatic logic [31:0] sum(input int w);
    return (w == 32) ? s32 : {28'b0, s4};
  endfunction
  function automatic logic cout(input int w);
    return (w == 32) ? co32 : co4;
  endfunction

  task automatic drive(input int w, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    if (w == 32) begin
      v32 = v; a32 = a; b32 = b; c32 = c;
    end else begin
      v4 = v; a4 = a[3:0]; b4 = b[3:0]; c4 = c;
    end
  endtask

  task automatic set_ready(input int w, input logic r);
    if (w == 32) ri32 = r; else ri4 = r;
  endtask

  // Issue one op at a negedge, check latency/result, hold the result for hold cycles
  // while poking valid_i and operands, then hand it off.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic c,
                        input int hold, input string tag);
    logic [32:0] full;
    logic [31:0] m, exp_s;
    logic        exp_c;
    int j;
    m     = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_000F;
    full  = {1'b0, a & m} + {1'b0, b & m} + {32'b0, c};
    exp_s = full[31:0] & m;
    exp_c = (w == 32) ? full[32] : full[4];
    drive(w, 1'b1, a, b, c);
    j = 0;
    while (!rdy(w) && j < 50) begin @(negedge clk); j++; end
    chk({tag, " accept_ready"}, rdy(w), 1'b1);
    @(negedge clk);
    drive(w, 1'b0, ~a, ~b, ~c);
    j = 0;
    while (!vld(w) && j < 50) begin @(negedge clk); j++; end
    chk({tag, " latency"}, j, w / 4);
    chk({tag, " sum"}, sum(w), exp_s);
    chk({tag, " carry"}, cout(w), exp_c);
    for (int k = 0; k < hold; k++) begin
      drive(w, k[0] ? 1'b0 : 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
      @(negedge clk);
      chk({tag, " hold_valid"}, vld(w), 1'b1);
      chk({tag, " hold_ready"}, rdy(w), 1'b0);
      chk({tag, " hold_sum"}, {cout(w), sum(w)}, {exp_c, exp_s});
    end
    drive(w, 1'b0, a, b, c);
    set_ready(w, 1'b1);
    @(negedge clk);
    set_ready(w, 1'b0);
    chk({tag, " post_valid"}, vld(w), 1'b0);
    chk({tag, " post_ready"}, rdy(w), 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    drive(32, 1'b0, 0, 0, 1'b0);
    drive(4, 1'b0, 0, 0, 1'b0);
    ri32 = 1'b0; ri4 = 1'b0;
    #1;
    chk("rst ready", r32_o, 1'b1);
    chk("rst valid", vo32, 1'b0);
    chk("rst sum", {co32, s32}, 33'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle ready/valid", {r32_o, vo32, r4_o, vo4}, 4'b1010);
      chk("idle sum", {co32, s32, co4, s4}, 38'h0);
    end

    run_op(32, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0, "ripple");
    run_op(32, 32'h1234_5678, 32'h1111_1111, 1'b1, 5, "bp");

    // Async reset between edges during the 3rd CALC cycle.
    drive(32, 1'b1, 32'hAAAA_5555, 32'h0F0F_F0F0, 1'b1);
    @(negedge clk);
    drive(32, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst valid", vo32, 1'b0);
    chk("midrst ready", r32_o, 1'b1);
    chk("midrst sum", {co32, s32}, 33'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    run_op(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1, "after_rst");

    run_op(4, 32'hF, 32'h1, 1'b1, 0, "w4_dir");

    for (int i = 0; i < 1000; i++)
      run_op(32, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), "rnd32");
    for (int i = 0; i < 1000; i++)
      run_op(4, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), "rnd4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
